// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-WB instruction bus and writeback/bypass/retire outputs
interface wb_stage_if;
  logic        in_valid;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_load_word;
  logic [31:0] in_pc_plus4;
  logic [31:0] data_rd;
  logic [4:0]  addr_rd;
  logic        write_enable;
  logic        prev_we;
  logic [4:0]  prev_addr;
  logic [31:0] prev_data;
  logic        illegal_load;
  logic        retire;
  logic [63:0] instret;

  modport master (
    output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_load_word, in_pc_plus4,
    input  data_rd, addr_rd, write_enable, prev_we, prev_addr, prev_data,
           illegal_load, retire, instret
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3,
           in_alu_result, in_load_word, in_pc_plus4,
    output data_rd, addr_rd, write_enable, prev_we, prev_addr, prev_data,
           illegal_load, retire, instret
  );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load extraction, regfile write port, bypass copy, instret
module wb_stage (
  input  logic      clock,
  input  logic      reset,
  wb_stage_if.slave bus
);
  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] load_q, load_d;
  logic [31:0] pc4_q, pc4_d;
  logic        prev_we_q, prev_we_d;
  logic [4:0]  prev_addr_q, prev_addr_d;
  logic [31:0] prev_data_q, prev_data_d;
  logic [63:0] instret_q, instret_d;

  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;
  logic [31:0] wb_data;
  logic        illegal;
  logic        we;
  logic        ret;

  always_comb begin
    load_byte = load_q[7:0];
    case (alu_q[1:0])
      2'd1:    load_byte = load_q[15:8];
      2'd2:    load_byte = load_q[23:16];
      2'd3:    load_byte = load_q[31:24];
      default: load_byte = load_q[7:0];
    endcase
    // Halfword uses only alu_q[1], so offset 3 quietly reads the upper half.
    load_half = alu_q[1] ? load_q[31:16] : load_q[15:0];

    load_val = load_q;
    illegal  = 1'b0;
    case (funct3_q)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_val = {24'd0, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b101:  load_val = {16'd0, load_half};
      3'b010:  load_val = load_q;
      default: illegal  = valid_q & (wb_sel_q == 2'b01);
    endcase

    case (wb_sel_q)
      2'b00:   wb_data = alu_q;
      2'b01:   wb_data = load_val;
      2'b10:   wb_data = pc4_q;
      default: wb_data = 32'd0;
    endcase

    we  = valid_q & reg_write_q & (rd_q != 5'd0) & (wb_sel_q != 2'b11) & ~illegal;
    ret = valid_q & ~illegal;

    valid_d     = bus.in_valid;
    reg_write_d = bus.in_reg_write;
    rd_d        = bus.in_rd;
    wb_sel_d    = bus.in_wb_sel;
    funct3_d    = bus.in_funct3;
    alu_d       = bus.in_alu_result;
    load_d      = bus.in_load_word;
    pc4_d       = bus.in_pc_plus4;
    prev_we_d   = we;
    prev_addr_d = we ? rd_q : 5'd0;
    prev_data_d = we ? wb_data : 32'd0;
    instret_d   = instret_q + (ret ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clock) begin
    reg_write_q <= reg_write_d;
    rd_q        <= rd_d;
    wb_sel_q    <= wb_sel_d;
    funct3_q    <= funct3_d;
    alu_q       <= alu_d;
    load_q      <= load_d;
    pc4_q       <= pc4_d;
    if (reset) begin
      valid_q     <= 1'b0;
      prev_we_q   <= 1'b0;
      prev_addr_q <= 5'd0;
      prev_data_q <= 32'd0;
      instret_q   <= 64'd0;
    end else begin
      valid_q     <= valid_d;
      prev_we_q   <= prev_we_d;
      prev_addr_q <= prev_addr_d;
      prev_data_q <= prev_data_d;
      instret_q   <= instret_d;
    end
  end

  assign bus.write_enable = we;
  assign bus.addr_rd      = we ? rd_q : 5'd0;
  assign bus.data_rd      = we ? wb_data : 32'd0;
  assign bus.prev_we      = prev_we_q;
  assign bus.prev_addr    = prev_addr_q;
  assign bus.prev_data    = prev_data_q;
  assign bus.illegal_load = illegal;
  assign bus.retire       = ret;
  assign bus.instret      = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - vector table with scoreboard queue plus reset/wrap sequences for wb_stage
module tb_wb_stage;
  logic clock;
  logic reset;
  wb_stage_if bus ();

  wb_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ill;
    logic        e_ret;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  vec_t        cur;
  vec_t        last;
  int          checks;
  int          errors;
  logic [63:0] model_instret;

  localparam logic [31:0] LW_DATA = 32'h80FF7F01;

  function automatic vec_t mk(logic v, logic rw, logic [4:0] rd, logic [1:0] sel,
                              logic [2:0] f3, logic [31:0] alu, logic [31:0] pc4,
                              logic e_we, logic [31:0] e_data, logic e_ill, logic e_ret);
    vec_t t;
    t.valid = v;  t.rw = rw;  t.rd = rd;  t.sel = sel;  t.f3 = f3;
    t.alu = alu;  t.ld = LW_DATA;  t.pc4 = pc4;
    t.e_we = e_we;  t.e_addr = e_we ? rd : 5'd0;  t.e_data = e_data;
    t.e_ill = e_ill;  t.e_ret = e_ret;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.in_valid      = t.valid;
    bus.in_reg_write  = t.rw;
    bus.in_rd         = t.rd;
    bus.in_wb_sel     = t.sel;
    bus.in_funct3     = t.f3;
    bus.in_alu_result = t.alu;
    bus.in_load_word  = t.ld;
    bus.in_pc_plus4   = t.pc4;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_instret = 64'd0;

    // valid rw rd sel f3 alu pc4 | we data ill ret
    vecs.push_back(mk(1, 1, 5'd3,  2'b00, 3'b000, 32'hDEADBEEF, 32'h0,   1, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd1,  2'b10, 3'b000, 32'h0,        32'h104, 1, 32'h00000104, 0, 1));
    vecs.push_back(mk(1, 1, 5'd10, 2'b01, 3'b000, 32'h1001,     32'h0,   1, 32'h0000007F, 0, 1));
    vecs.push_back(mk(1, 1, 5'd10, 2'b01, 3'b000, 32'h1002,     32'h0,   1, 32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd11, 2'b01, 3'b100, 32'h1003,     32'h0,   1, 32'h00000080, 0, 1));
    vecs.push_back(mk(1, 1, 5'd12, 2'b01, 3'b001, 32'h1003,     32'h0,   1, 32'hFFFF80FF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd13, 2'b01, 3'b101, 32'h1000,     32'h0,   1, 32'h00007F01, 0, 1));
    vecs.push_back(mk(1, 1, 5'd14, 2'b01, 3'b010, 32'h1002,     32'h0,   1, 32'h80FF7F01, 0, 1));
    vecs.push_back(mk(1, 1, 5'd15, 2'b01, 3'b000, 32'h1000,     32'h0,   1, 32'h00000001, 0, 1));
    vecs.push_back(mk(1, 1, 5'd16, 2'b01, 3'b001, 32'h1001,     32'h0,   1, 32'h00007F01, 0, 1));
    vecs.push_back(mk(1, 1, 5'd17, 2'b01, 3'b101, 32'h1002,     32'h0,   1, 32'h000080FF, 0, 1));
    vecs.push_back(mk(1, 1, 5'd0,  2'b00, 3'b000, 32'h5555,     32'h0,   0, 32'h0,        0, 1));
    vecs.push_back(mk(1, 1, 5'd4,  2'b11, 3'b000, 32'h6666,     32'h0,   0, 32'h0,        0, 1));
    vecs.push_back(mk(1, 1, 5'd5,  2'b01, 3'b011, 32'h1000,     32'h0,   0, 32'h0,        1, 0));
    vecs.push_back(mk(1, 1, 5'd5,  2'b01, 3'b110, 32'h1000,     32'h0,   0, 32'h0,        1, 0));
    vecs.push_back(mk(0, 1, 5'd6,  2'b00, 3'b000, 32'h7777,     32'h0,   0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 5'd8,  2'b00, 3'b011, 32'h2468,     32'h0,   1, 32'h00002468, 0, 1));
    vecs.push_back(mk(1, 0, 5'd9,  2'b00, 3'b000, 32'h8888,     32'h0,   0, 32'h0,        0, 1));
    vecs.push_back(mk(1, 1, 5'd3,  2'b00, 3'b000, 32'h11,       32'h0,   1, 32'h00000011, 0, 1));
    vecs.push_back(mk(1, 1, 5'd3,  2'b00, 3'b000, 32'h22,       32'h0,   1, 32'h00000022, 0, 1));
    vecs.push_back(mk(0, 0, 5'd0,  2'b00, 3'b000, 32'h0,        32'h0,   0, 32'h0,        0, 0));

    // Reset held two edges with a valid writing instruction presented.
    reset = 1'b1;
    drive(mk(1, 1, 5'd5, 2'b00, 3'b000, 32'h1234, 32'h0, 1, 32'h1234, 0, 1));
    for (int r = 0; r < 2; r++) begin
      step();
      chk("rst_we", {63'd0, bus.write_enable}, 64'd0);
      chk("rst_data", {32'd0, bus.data_rd}, 64'd0);
      chk("rst_instret", bus.instret, 64'd0);
      chk("rst_prev_we", {63'd0, bus.prev_we}, 64'd0);
      chk("rst_retire", {63'd0, bus.retire}, 64'd0);
    end
    reset = 1'b0;

    last = mk(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      step();
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        cur = sb.pop_front();
        chk($sformatf("v%0d_we", i), {63'd0, bus.write_enable}, {63'd0, cur.e_we});
        chk($sformatf("v%0d_addr", i), {59'd0, bus.addr_rd}, {59'd0, cur.e_addr});
        chk($sformatf("v%0d_data", i), {32'd0, bus.data_rd}, {32'd0, cur.e_data});
        chk($sformatf("v%0d_ill", i), {63'd0, bus.illegal_load}, {63'd0, cur.e_ill});
        chk($sformatf("v%0d_ret", i), {63'd0, bus.retire}, {63'd0, cur.e_ret});
        chk($sformatf("v%0d_prev_we", i), {63'd0, bus.prev_we}, {63'd0, last.e_we});
        chk($sformatf("v%0d_prev_addr", i), {59'd0, bus.prev_addr}, {59'd0, last.e_addr});
        chk($sformatf("v%0d_prev_data", i), {32'd0, bus.prev_data}, {32'd0, last.e_data});
        chk($sformatf("v%0d_instret", i), bus.instret, model_instret);
        if (cur.e_ret) model_instret = model_instret + 64'd1;
        last = cur;
      end
    end

    // Counter wrap: instruction sits in WB with retire=1 while the count is preloaded.
    drive(mk(1, 1, 5'd2, 2'b00, 3'b000, 32'h99, 32'h0, 1, 32'h99, 0, 1));
    step();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    chk("wrap_preload", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wrap_retire", {63'd0, bus.retire}, 64'd1);
    drive(mk(0, 0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 0, 32'h0, 0, 0));
    step();
    chk("wrap_zero", bus.instret, 64'd0);

    // Reset arriving while a write is already in WB: write shows this cycle, gone after.
    drive(mk(1, 1, 5'd7, 2'b00, 3'b000, 32'h55, 32'h0, 1, 32'h55, 0, 1));
    step();
    chk("midrst_pre_we", {63'd0, bus.write_enable}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_during_we", {63'd0, bus.write_enable}, 64'd1);
    chk("midrst_during_data", {32'd0, bus.data_rd}, 64'h55);
    step();
    chk("midrst_post_we", {63'd0, bus.write_enable}, 64'd0);
    chk("midrst_post_addr", {59'd0, bus.addr_rd}, 64'd0);
    chk("midrst_post_prev_we", {63'd0, bus.prev_we}, 64'd0);
    chk("midrst_post_instret", bus.instret, 64'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage pipeline. It registers the MEM-stage result, selects the write value (ALU result, extracted/extended load data, or PC+4), and drives the register file write port (`data_rd`, `addr_rd`, `write_enable`). It also exposes a one-cycle-delayed copy of the last write for the decode-stage bypass, and keeps the 64-bit retired-instruction counter.

## Interface
- No parameters.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: the MEM stage presents an instruction this cycle; 0 means bubble.
- `in_reg_write` in 1: the instruction writes rd.
- `in_rd` in 5: destination register.
- `in_wb_sel` in 2: write source.
  - 00: ALU.
  - 01: load.
  - 10: PC+4.
  - 11: reserved.
- `in_funct3` in 3: load type.
- `in_alu_result` in 32: ALU result; for loads, the byte address.
- `in_load_word` in 32: aligned word read from data memory.
- `in_pc_plus4` in 32: link value.
- `data_rd` out 32: register file write data.
- `addr_rd` out 5: register file write address.
- `write_enable` out 1: register file write strobe.
- `prev_we` out 1: the previous cycle's `write_enable`, registered.
- `prev_addr` out 5: the previous cycle's `addr_rd`, registered.
- `prev_data` out 32: the previous cycle's `data_rd`, registered.
- `illegal_load` out 1: the instruction now in WB is a load with an undefined funct3.
- `retire` out 1: the instruction now in WB retires.
- `instret` out 64: count of retired instructions.

## Operation
- **WB register.** On each rising edge the block captures all `in_*` into the WB register; `valid_q <= in_valid`. It has no stall or hold; a bubble is delivered as `in_valid=0`.
- **Load extraction.** Byte offset is `alu_q[1:0]`.
  - 000 LB: byte at bits [8*off+7 : 8*off], sign-extended.
  - 100 LBU: the same byte, zero-extended.
  - 001 LH: halfword at `alu_q[1]` (bits [31:16] if set, else [15:0]), sign-extended. `alu_q[0]` is ignored.
  - 101 LHU: the same halfword, zero-extended.
  - 010 LW: the full word. `alu_q[1:0]` is ignored.
  - 011, 110, 111: undefined. `illegal_load` = `valid_q & (wb_sel_q==01)`.
- **Write value.** `wb_sel` 00 selects `alu_q`, 01 the extracted load, 10 `pc4_q`. `wb_sel` 11 suppresses the write.
- **write_enable** = `valid_q & reg_write_q & (rd_q != 0) & (wb_sel_q != 11) & ~illegal_load`.
- **Write port outputs.**
  - When `write_enable=1`: `addr_rd = rd_q`, `data_rd` = the selected value.
  - When `write_enable=0`: both are forced to 0.
- **retire** = `valid_q & ~illegal_load`. Retirement does not require a register write (stores, branches and writes to x0 still retire).
- **instret** increments by 1 on each rising edge where `retire=1`. It wraps from 2^64−1 to 0.
- **Bypass.** On every edge: `prev_we <= write_enable`, `prev_addr <= addr_rd`, `prev_data <= data_rd`. Decode uses these to correct a read of a register written in the immediately preceding cycle.

## Timing
- **Latency.** Inputs sampled at edge N appear on `write_enable`/`addr_rd`/`data_rd` after edge N. These outputs are combinational from the WB register. The register file commits the write at edge N+1.
- **Bypass and counter.** `prev_*` reflect edge-N inputs after edge N+1. `instret` reflects a retirement at edge N after edge N+1.
- **Throughput.** One instruction per cycle. Back-to-back writes to the same rd are legal; each one appears for exactly one cycle.
- **Reset.** Sampled at an edge with `reset=1`:
  - `valid_q`, `prev_we`, `prev_addr`, `prev_data` and `instret` are cleared.
  - Consequently `write_enable`, `addr_rd`, `data_rd`, `retire` and `illegal_load` are all 0.
  - Reset has priority over `in_valid`. The instruction presented in that cycle is dropped: no write, no count.
- **Reset mid-operation.** An instruction already in WB when reset is sampled still drives its write during that cycle; it is gone after the edge.
- **Word boundary.** An LH at offset 3 returns bits [31:16]. No fault is raised.

## Test plan
- **Reset.** Hold reset 2 cycles with `in_valid=1`, rd=5, ALU=0x1234 → after each edge `write_enable=0`, `data_rd=0`, `instret=0`, `prev_we=0`.
- **ALU and link writes.** ALU write rd=3, value 0xDEADBEEF, then PC+4 write rd=1, `pc_plus4=0x104` → `write_enable` for two consecutive cycles with (3, 0xDEADBEEF) then (1, 0x104). `prev_*` lag by one cycle. `instret` goes 0→1→2.
- **Load extraction.** `in_load_word=0x80FF7F01`:
  - LB offset 1 → 0x0000007F.
  - LB offset 2 → 0xFFFFFFFF.
  - LBU offset 3 → 0x00000080.
  - LH offset 3 → 0xFFFF80FF.
  - LHU offset 0 → 0x00007F01.
  - LW offset 2 → 0x80FF7F01.
- **Suppressed writes.**
  - rd=0 ALU write → `write_enable=0`, `retire=1`.
  - `wb_sel=11` → no write.
  - funct3=011 load → `illegal_load=1`, `retire=0`, `instret` unchanged.
  - `in_valid=0` bubble → no write, no retire.
- **Counter wrap.** Preload `instret` to 2^64−1 via hierarchical force, then retire one instruction → `instret=0`.
